// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register.
//   pipe_state_e  : control FSM states; encoding equals the entry count.
//   PIPE_PC_RESET : default reset vector used by the PC stage.
`ifndef PIPE_STAGE_REG_PKG_SV
`define PIPE_STAGE_REG_PKG_SV
package pipe_stage_reg_pkg;

   typedef enum logic [1:0] {
      PIPE_ST_EMPTY = 2'd0,
      PIPE_ST_ONE   = 2'd1,
      PIPE_ST_TWO   = 2'd2
   } pipe_state_e;

   localparam logic [31:0] PIPE_PC_RESET = 32'h0040_0020;

endpackage
`endif

// File: rtl/pipe_stage_entry.sv
// Single WIDTH-wide storage entry of a pipeline stage.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   clr_i    : synchronous clear to RESET_VALUE (wins over load_i)
//   load_i   : capture d_i at the next rising edge
//   d_i      : data to load
//   q_o      : stored value
module pipe_stage_entry #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         data_q <= RESET_VALUE;
      else if (clr_i)  data_q <= RESET_VALUE;
      else if (load_i) data_q <= d_i;
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush
// and configurable reset value.
// Build option: define PIPE_STAGE_REG_SKID_EN to add a skid entry, which
// makes in_ready a flop output (no combinational path from out_ready) and
// lets the stage hold two entries.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   flush               : synchronous kill of all held entries
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data = head entry
//   occupancy           : entries held (0..2, 0..1 without skid)
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   pipe_state_e      state_q, state_d;
   logic             accept, consume;
   logic             main_load;
   logic [WIDTH-1:0] main_d, main_q;
`ifdef PIPE_STAGE_REG_SKID_EN
   logic             skid_load;
   logic [WIDTH-1:0] skid_q;
   logic             in_ready_q, in_ready_d;
`endif

   assign accept  = in_valid && in_ready;
   assign consume = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= PIPE_ST_EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      main_d    = in_data;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_load = 1'b0;
`endif
      if (flush) begin
         state_d = PIPE_ST_EMPTY;
      end else begin
         case (state_q)
            PIPE_ST_EMPTY: begin
               if (accept) begin
                  state_d   = PIPE_ST_ONE;
                  main_load = 1'b1;
               end
            end
            PIPE_ST_ONE: begin
               if (accept && consume) begin
                  main_load = 1'b1;
               end else if (consume) begin
                  state_d = PIPE_ST_EMPTY;
`ifdef PIPE_STAGE_REG_SKID_EN
               end else if (accept) begin
                  state_d   = PIPE_ST_TWO;
                  skid_load = 1'b1;
`endif
               end
            end
`ifdef PIPE_STAGE_REG_SKID_EN
            PIPE_ST_TWO: begin
               if (consume) begin
                  state_d   = PIPE_ST_ONE;
                  main_load = 1'b1;
                  main_d    = skid_q;
               end
            end
`endif
            default: state_d = PIPE_ST_EMPTY;
         endcase
      end
   end

   pipe_stage_entry #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_main (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (flush),
      .load_i (main_load),
      .d_i    (main_d),
      .q_o    (main_q)
   );

`ifdef PIPE_STAGE_REG_SKID_EN
   pipe_stage_entry #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (flush),
      .load_i (skid_load),
      .d_i    (in_data),
      .q_o    (skid_q)
   );

   // Ready is precomputed from the next state so it is a clean flop output.
   assign in_ready_d = (state_d != PIPE_ST_TWO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_ready_q <= 1'b1;
      else     in_ready_q <= in_ready_d;
   end

   assign in_ready  = in_ready_q;
   assign occupancy = state_q;
`else
   assign in_ready  = !out_valid || out_ready;
   assign occupancy = {1'b0, state_q == PIPE_ST_ONE};
`endif

   assign out_valid = (state_q != PIPE_ST_EMPTY);
   assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
   import pipe_stage_reg_pkg::*;

   localparam int             W  = 32;
   localparam logic [W-1:0]   RV = W'(PIPE_PC_RESET);

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Reference model: the entries the stage should hold, oldest first,
   // plus the value out_data must show when nothing is held.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] hold = RV;

   pipe_stage_reg #(
      .WIDTH       (W),
      .RESET_VALUE (RV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
      return exp_q.size() < 2;
`else
      return (exp_q.size() == 0) || out_ready;
`endif
   endfunction

   // Monitor: checks every cycle and pops the scoreboard on a consume.
   initial begin
      logic [W-1:0] v;
      forever begin
         @(negedge clk);
         #1;
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
         chk("in_ready",  64'(in_ready),  64'(model_ready()));
         if (exp_q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0]));
            if (out_ready) begin
               v    = exp_q.pop_front();
               hold = v;
            end
         end else begin
            chk("out_data_idle", 64'(out_data), 64'(hold));
         end
      end
   end

   // One cycle of stimulus; the model is updated at the edge.
   task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic fl, output logic acc);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      acc       = iv && model_ready() && !fl;
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
         hold = RV;
      end else if (acc) begin
         exp_q.push_back(d);
      end
   endtask

   task automatic idle(input int unsigned n);
      logic acc;
      for (int unsigned i = 0; i < n; i++) step(1'b0, W'($urandom()), 1'b1, 1'b0, acc);
   endtask

   // Offer d with the sink stalled for two attempts, then released.
   task automatic send_bp(input logic [W-1:0] d);
      logic        acc = 1'b0;
      int unsigned att = 0;
      while (!acc && att < 8) begin
         step(1'b1, d, att >= 2, 1'b0, acc);
         att++;
      end
      chk("bp_accept", 64'(acc), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic         acc;
      logic [W-1:0] d;
      // Hold reset through two edges, checked by the monitor.
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;

      // Streaming.
      step(1'b1, W'(1), 1'b1, 1'b0, acc);
      step(1'b1, W'(2), 1'b1, 1'b0, acc);
      step(1'b1, W'(3), 1'b1, 1'b0, acc);
      idle(3);

      // Backpressure.
      send_bp(W'('hA));
      send_bp(W'('hB));
      send_bp(W'('hC));
      idle(4);

      // Flush while full with a beat offered.
      step(1'b1, W'('h11), 1'b0, 1'b0, acc);
      step(1'b1, W'('h22), 1'b0, 1'b0, acc);
      step(1'b1, W'('h33), 1'b0, 1'b1, acc);
      idle(3);

      // Asynchronous reset mid-cycle with an entry held.
      step(1'b1, W'('h44), 1'b0, 1'b0, acc);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'(RV));
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      exp_q.delete();
      hold = RV;
      @(negedge clk);
      #2 rst = 1'b0;
      idle(2);

      // Randomized traffic.
      for (int unsigned i = 0; i < 2000; i++) begin
         d = W'({$urandom(), $urandom()});
         step(($urandom() % 4) != 0, d, ($urandom() % 3) != 0,
              ($urandom() % 32) == 0, acc);
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
